// File: rtl/pal_arbiter.sv
// Round-robin arbiter that funnels N_REQ requesters into one registered request port
// and routes in-order responses back to the requester that issued each transaction.
module pal_arbiter #(
  parameter int unsigned W_DATA  = 32,
  parameter int unsigned W_ADDR  = 16,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                        i_clk,
  input  logic                        resetn,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*W_ADDR-1:0]     req_addr,
  input  logic [N_REQ*W_DATA-1:0]     req_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [W_ADDR-1:0]           m_addr,
  output logic [W_DATA-1:0]           m_data,
  input  logic                        s_rsp_valid,
  input  logic [W_DATA-1:0]           s_rsp_data,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [W_DATA-1:0]           rsp_data,
  output logic [$clog2(MAX_OUT):0]    o_outstanding,
  output logic                        o_err
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned AW = $clog2(MAX_OUT);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     grant;
  logic              found;
  logic              accept;
  logic              pop;
  logic [W_ADDR-1:0] sel_addr;
  logic [W_DATA-1:0] sel_data;
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     ids_q [MAX_OUT];

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IW'(idx);
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant == IW'(i)) begin
        sel_addr = req_addr[i*W_ADDR +: W_ADDR];
        sel_data = req_data[i*W_DATA +: W_DATA];
      end
    end
  end

  // resetn gates the combinational ready so nothing is accepted while reset is held.
  assign accept    = resetn && found && (!m_valid || m_ready) && (cnt_q < CW'(MAX_OUT));
  assign req_ready = accept ? (N_REQ'(1) << grant) : '0;
  assign pop       = s_rsp_valid && (cnt_q != '0);

  assign o_outstanding = cnt_q;

  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q     <= '0;
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_data    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      o_err     <= 1'b0;
    end else begin
      if (accept) begin
        m_valid <= 1'b1;
        m_addr  <= sel_addr;
        m_data  <= sel_data;
        ptr_q   <= (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
        wr_q    <= wr_q + 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      unique case ({accept, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      if (pop) begin
        rd_q      <= rd_q + 1'b1;
        rsp_valid <= N_REQ'(1) << ids_q[rd_q];
        rsp_data  <= s_rsp_data;
      end else begin
        rsp_valid <= '0;
      end

      // A response with nothing outstanding is a protocol violation; flag stays until reset.
      if (s_rsp_valid && (cnt_q == '0)) o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) ids_q[wr_q] <= grant;
  end

endmodule

// File: tb/tb_pal_arbiter.sv
// Randomized and directed bench for pal_arbiter against a queue-based transaction model.
module tb_pal_arbiter;

  localparam int N  = 4;
  localparam int MO = 4;
  localparam int WA = 16;
  localparam int WD = 32;

  logic                 i_clk = 1'b0;
  logic                 resetn;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*WA-1:0]      req_addr;
  logic [N*WD-1:0]      req_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [WA-1:0]        m_addr;
  logic [WD-1:0]        m_data;
  logic                 s_rsp_valid;
  logic [WD-1:0]        s_rsp_data;
  logic [N-1:0]         rsp_valid;
  logic [WD-1:0]        rsp_data;
  logic [$clog2(MO):0]  o_outstanding;
  logic                 o_err;

  pal_arbiter #(
    .W_DATA  (WD),
    .W_ADDR  (WA),
    .N_REQ   (N),
    .MAX_OUT (MO)
  ) dut (
    .i_clk         (i_clk),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_addr        (m_addr),
    .m_data        (m_data),
    .s_rsp_valid   (s_rsp_valid),
    .s_rsp_data    (s_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .o_outstanding (o_outstanding),
    .o_err         (o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: ids of accepted requests awaiting responses, in issue order.
  int            ptr_m;
  int            q_m[$];
  bit            mv_m;
  logic [WA-1:0] ma_m;
  logic [WD-1:0] md_m;
  logic [N-1:0]  rv_m;
  logic [WD-1:0] rd_m;
  bit            err_m;
  int            last_grant;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    q_m.delete();
    mv_m  = 0;
    ma_m  = '0;
    md_m  = '0;
    rv_m  = '0;
    rd_m  = '0;
    err_m = 0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input logic [N-1:0] v, input bit mr, input bit rs);
    int           g;
    bit           acc;
    logic [N-1:0] exp_rr;
    @(negedge i_clk);
    req_valid   = v;
    m_ready     = mr;
    s_rsp_valid = rs;
    for (int i = 0; i < N; i++) begin
      req_addr[i*WA +: WA] = WA'($urandom);
      req_data[i*WD +: WD] = $urandom;
    end
    s_rsp_data = $urandom;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
    end
    acc    = (g >= 0) && (!mv_m || mr) && (q_m.size() < MO);
    exp_rr = acc ? N'(1 << g) : '0;
    check("req_ready", 64'(req_ready), 64'(exp_rr));
    check("m_valid", 64'(m_valid), 64'(mv_m));
    check("m_addr", 64'(m_addr), 64'(ma_m));
    check("m_data", 64'(m_data), 64'(md_m));
    check("rsp_valid", 64'(rsp_valid), 64'(rv_m));
    check("rsp_data", 64'(rsp_data), 64'(rd_m));
    check("outstanding", 64'(o_outstanding), 64'(q_m.size()));
    check("err", 64'(o_err), 64'(err_m));
    last_grant = acc ? g : -1;
    if (acc) begin
      mv_m  = 1;
      ma_m  = req_addr[g*WA +: WA];
      md_m  = req_data[g*WD +: WD];
      ptr_m = (g + 1) % N;
    end else if (mv_m && mr) begin
      mv_m = 0;
    end
    if (rs && q_m.size() > 0) begin
      rv_m = N'(1 << q_m.pop_front());
      rd_m = s_rsp_data;
    end else begin
      rv_m = '0;
      if (rs) err_m = 1;
    end
    if (acc) q_m.push_back(g);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    req_valid   = '1;
    m_ready     = 1'b1;
    s_rsp_valid = 1'b0;
    resetn      = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_count", 64'(o_outstanding), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    model_reset();
    @(negedge i_clk);
    req_valid = '0;
    resetn    = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    m_ready     = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp_data  = '0;
    model_reset();
    do_reset();

    // Lone requester 2 from ptr 0, then ptr 3 makes requester 0 win over 2.
    step(4'b0100, 1'b1, 1'b0);
    check("lone_grant", 64'(last_grant), 64'd2);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    check("wrap_grant", 64'(last_grant), 64'd0);
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, (q_m.size() > 0));

    // All requesting, responses trailing by two cycles: strict rotation.
    for (int i = 0; i < 12; i++) begin
      step(4'b1111, 1'b1, (i >= 2));
      check("rr_grant", 64'(last_grant), 64'((ptr_m + N - 1) % N));
    end
    for (int i = 0; i < 6; i++) step(4'b0000, 1'b1, (q_m.size() > 0));

    // Downstream stall holds the output register.
    do_reset();
    step(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0);

    // Fill to MAX_OUT with no responses, then free one slot.
    do_reset();
    for (int i = 0; i < 7; i++) step(4'b1111, 1'b1, 1'b0);
    check("full_count", 64'(o_outstanding), 64'(MO));
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    check("refill_grant", 64'(last_grant >= 0), 64'd1);

    // Spurious response sets a sticky error.
    do_reset();
    step(4'b0000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b0);
    check("err_sticky", 64'(o_err), 64'd1);

    // Reset with transactions in flight, then restart from ptr 0.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
    do_reset();
    step(4'b1010, 1'b1, 1'b0);
    check("post_rst_grant", 64'(last_grant), 64'd1);
    step(4'b0000, 1'b1, 1'b1);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step(N'($urandom), ($urandom_range(0, 3) != 0),
           (q_m.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
